// File: rtl/ysyx_22040632_div_ctrl.sv
// ysyx_22040632_div_ctrl: sequencing stage in front of the iterative divider.
// Resolves divide-by-zero and signed overflow locally in one cycle. Everything
// else is handed to the divider, and the quotient or remainder is picked from
// its result. The result is then held for writeback until it is accepted.
// Only XLEN=64 is supported, because the W sign-extension is hard-wired to 32 bits.
module ysyx_22040632_div_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rrst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            flush,
  output logic            div_valid,
  input  logic            div_ready,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic            div_divw,
  output logic            div_signed,
  output logic            div_flush,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, next_state;
  logic [XLEN-1:0] src1_q, src2_q, res_q;
  logic [1:0]      op_q;
  logic            word_q, signed_q, div_flush_q;

  logic            accept;
  logic            is_zero, is_min, is_ones, is_ovf, is_special;
  logic [XLEN-1:0] src1_ext, special_res;

  assign accept = in_valid & in_ready & ~flush;

  // W operations look only at the low word. The dividend is sign-extended
  // because both special-case results that return it are 32-bit values.
  assign src1_ext = in_word ? {{(XLEN-32){in_src1[31]}}, in_src1[31:0]} : in_src1;
  assign is_zero  = in_word ? (in_src2[31:0] == 32'd0) : (in_src2 == '0);
  assign is_min   = in_word ? (in_src1[31:0] == 32'h8000_0000)
                            : (in_src1 == {1'b1, {(XLEN-1){1'b0}}});
  assign is_ones  = in_word ? (&in_src2[31:0]) : (&in_src2);
  assign is_ovf   = ~in_op[0] & is_min & is_ones;
  assign is_special = is_zero | is_ovf;

  // Divide-by-zero takes priority over overflow when both conditions hold.
  assign special_res = is_zero ? (in_op[1] ? src1_ext : {XLEN{1'b1}})
                               : (in_op[1] ? {XLEN{1'b0}} : src1_ext);

  // State register
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic. Flush overrides every other transition.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (accept)        next_state = is_special ? DONE : ISSUE;
        ISSUE: if (div_ready)     next_state = WAIT;
        WAIT:  if (div_out_valid) next_state = DONE;
        DONE:  if (res_ready)     next_state = IDLE;
        default:                  next_state = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from the state only
  always_comb begin
    in_ready  = (state == IDLE);
    div_valid = (state == ISSUE);
    res_valid = (state == DONE);
  end

  // Operand latch, result capture and the divider abort pulse
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      src1_q      <= '0;
      src2_q      <= '0;
      op_q        <= '0;
      word_q      <= 1'b0;
      signed_q    <= 1'b0;
      res_q       <= '0;
      div_flush_q <= 1'b0;
    end else begin
      div_flush_q <= flush & ((state == WAIT) | ((state == ISSUE) & div_ready));
      if (accept) begin
        src1_q   <= in_src1;
        src2_q   <= in_src2;
        op_q     <= in_op;
        word_q   <= in_word;
        signed_q <= ~in_op[0];
        if (is_special) res_q <= special_res;
      end else if ((state == WAIT) && div_out_valid && !flush) begin
        res_q <= op_q[1] ? div_remainder : div_quotient;
      end
    end
  end

  assign div_dividend = src1_q;
  assign div_divisor  = src2_q;
  assign div_divw     = word_q;
  assign div_signed   = signed_q;
  assign div_flush    = div_flush_q;
  assign res_data     = res_q;

endmodule
